alu_dmem_unit: RTL and testbench
================================

Name: alu_dmem_unit

Overview:
- Execute/memory slice of the single-cycle MIPS core.
- A combinational 32-bit ALU performs add/sub, logic, shift and compare, controlled by the 6-bit ALUFun code from the control decoder.
- The ALU result also serves as the byte address of a word-organised data RAM.
- The RAM has a combinational read and writes on the rising clock edge.
- The top level ORs this block's read data with peripheral read data, so this block's read data is 0 when it is not selected.

Parameters:
- DEPTH, 256, number of 32-bit words in the data RAM.
- ADDR_BITS, 8, word-index width; must equal log2(DEPTH).

Ports:
- clk, input, 1, system clock; writes occur on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- alu_a, input, 32, operand A; the shift amount is taken from alu_a[4:0].
- alu_b, input, 32, operand B; this is the value being shifted for shift operations.
- alu_fun, input, 6, operation select.
- sign, input, 1, 1 = signed compare/overflow, 0 = unsigned.
- mem_rd, input, 1, read enable.
- mem_wr, input, 1, write enable.
- wdata, input, 32, store data.
- alu_out, output, 32, ALU result, also the RAM byte address.
- overflow, output, 1, signed arithmetic overflow flag.
- rdata, output, 32, RAM read data.

Behaviour:
- ALU is purely combinational; alu_out and overflow depend only on alu_a, alu_b, alu_fun and sign.
- alu_fun[5:4]=00, arithmetic:
  - alu_fun[0]=0: A+B.
  - alu_fun[0]=1: A-B, computed as A+~B+1.
  - Result wraps modulo 2^32.
- alu_fun[5:4]=01, logic, selected by alu_fun[3:0]:
  - 1000 = A&B.
  - 1110 = A|B.
  - 0110 = A^B.
  - 0001 = ~(A|B).
  - 1010 = A (pass).
  - Any other code yields 0.
- alu_fun[5:4]=10, shift, selected by alu_fun[1:0], shift amount alu_a[4:0]:
  - 00 = B<<A[4:0].
  - 01 = B>>A[4:0], logical.
  - 11 = B>>>A[4:0], arithmetic (sign bit replicated).
  - 10 yields 0.
- alu_fun[5:4]=11, compare; alu_out = {31'b0, flag}, with flag selected by alu_fun[3:1]:
  - 001 EQ: A==B.
  - 000 NEQ: A!=B.
  - 010 LT: A<B; signed when sign=1, unsigned when sign=0.
  - 110 LEZ: A<=0, signed.
  - 101 LTZ: A<0, signed.
  - 111 GTZ: A>0, signed.
  - Other codes give flag=0.
  - LEZ/LTZ/GTZ always treat A as signed and ignore B.
- overflow:
  - Asserted only when alu_fun[5:4]=00 and sign=1 and signed overflow occurs.
  - Signed overflow: operands (B inverted for subtract) have the same sign bit and the result sign differs.
  - overflow is 0 for every other group and whenever sign=0.
- RAM addressing:
  - Word index = alu_out[ADDR_BITS+1:2]; alu_out[1:0] is ignored (no misalignment fault).
  - Address in range iff alu_out < 4*DEPTH.
- RAM read: rdata = mem[index] when mem_rd=1 and the address is in range; otherwise rdata=0. Combinational, zero-latency.
- RAM write:
  - On the rising clk edge with reset=1, mem_wr=1 and the address in range, mem[index] <= wdata.
  - Out-of-range writes are dropped silently.
- Write/read ordering: new data becomes visible on rdata after the edge. Read and write in the same cycle to the same address returns the old data before the edge.
- Reset (reset=0):
  - Asynchronous; blocks writes for as long as it is held.
  - Outputs remain combinational functions of the inputs; no output register exists.
  - RAM contents per the optional feature below.

Optional Feature:
- Macro: DMEM_RESET_CLEAR_EN.
- Defined: assertion of reset asynchronously clears every RAM word to 0, and reads after release return 0 until the word is written.
- Undefined: reset only inhibits writes; RAM contents are retained across reset and are undefined at power-up.

Test Plan:
- Add overflow: alu_a=0x7FFFFFFF, alu_b=1, alu_fun=000000, sign=1 -> alu_out=0x80000000, overflow=1; same with sign=0 -> overflow=0.
- Subtract and compare:
  - alu_fun=000001, A=5, B=7 -> alu_out=0xFFFFFFFE, overflow=0.
  - LT (110101), A=0xFFFFFFFF, B=1: sign=1 -> alu_out=1; sign=0 -> alu_out=0.
- Logic: A=0xF0F0F0F0, B=0x0FF00FF0:
  - AND -> 0x00F000F0.
  - OR -> 0xFFF0FFF0.
  - XOR -> 0xFF00FF00.
  - NOR -> 0x000F000F.
- Shift: B=0x80000010, A[4:0]=4:
  - SLL -> 0x00000100.
  - SRL -> 0x08000001.
  - SRA -> 0xF8000001.
- RAM:
  - Write 0xDEADBEEF at address 0x00000010 (ADD, A=0x10, B=0); the next cycle with mem_rd=1 -> rdata=0xDEADBEEF.
  - With mem_rd=0 -> rdata=0.
  - Write at address 0x400 with DEPTH=256 -> ignored, read returns 0.
- Reset: write 0x12345678 at word 3, pulse reset low mid-cycle -> with DMEM_RESET_CLEAR_EN the read returns 0; without it the read returns 0x12345678. A write attempted while reset is low has no effect.

Source files
------------

// File: rtl/alu_dmem_unit_if.sv
// Operand, control and data bus between the control path and the ALU/data-memory slice.
// The master drives operands and memory controls; the slave returns the ALU result and read data.
interface alu_dmem_unit_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [5:0]  alu_fun;
  logic        sign;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] wdata;
  logic [31:0] alu_out;
  logic        overflow;
  logic [31:0] rdata;

  modport master (
    output alu_a, alu_b, alu_fun, sign, mem_rd, mem_wr, wdata,
    input  alu_out, overflow, rdata
  );

  modport slave (
    input  alu_a, alu_b, alu_fun, sign, mem_rd, mem_wr, wdata,
    output alu_out, overflow, rdata
  );
endinterface

// File: rtl/alu_dmem_unit.sv
// Execute/memory slice: combinational 32-bit ALU whose result addresses a word-organised data RAM.
// Optional macro DMEM_RESET_CLEAR_EN makes reset clear the whole RAM; otherwise reset only blocks writes.
module alu_dmem_unit #(
  parameter int DEPTH     = 256,
  parameter int ADDR_BITS = 8
) (
  input  logic            clk,
  input  logic            reset,
  alu_dmem_unit_if.slave  bus
);

  logic [31:0]          b_eff;
  logic [31:0]          sum;
  logic [4:0]           shamt;
  logic                 lt;
  logic                 flag;
  logic                 in_range;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          mem [DEPTH];

  // Subtract reuses the adder as A + ~B + 1
  always_comb begin
    b_eff = bus.alu_fun[0] ? ~bus.alu_b : bus.alu_b;
    sum   = bus.alu_a + b_eff + {31'b0, bus.alu_fun[0]};
    shamt = bus.alu_a[4:0];
    lt    = bus.sign ? ($signed(bus.alu_a) < $signed(bus.alu_b)) : (bus.alu_a < bus.alu_b);
  end

  always_comb begin
    flag = 1'b0;
    case (bus.alu_fun[3:1])
      3'b001:  flag = (bus.alu_a == bus.alu_b);
      3'b000:  flag = (bus.alu_a != bus.alu_b);
      3'b010:  flag = lt;
      3'b110:  flag = bus.alu_a[31] || (bus.alu_a == 32'd0);
      3'b101:  flag = bus.alu_a[31];
      3'b111:  flag = !bus.alu_a[31] && (bus.alu_a != 32'd0);
      default: flag = 1'b0;
    endcase
  end

  always_comb begin
    bus.alu_out = 32'd0;
    case (bus.alu_fun[5:4])
      2'b00: bus.alu_out = sum;
      2'b01: begin
        case (bus.alu_fun[3:0])
          4'b1000: bus.alu_out = bus.alu_a & bus.alu_b;
          4'b1110: bus.alu_out = bus.alu_a | bus.alu_b;
          4'b0110: bus.alu_out = bus.alu_a ^ bus.alu_b;
          4'b0001: bus.alu_out = ~(bus.alu_a | bus.alu_b);
          4'b1010: bus.alu_out = bus.alu_a;
          default: bus.alu_out = 32'd0;
        endcase
      end
      2'b10: begin
        case (bus.alu_fun[1:0])
          2'b00:   bus.alu_out = bus.alu_b << shamt;
          2'b01:   bus.alu_out = bus.alu_b >> shamt;
          2'b11:   bus.alu_out = $unsigned($signed(bus.alu_b) >>> shamt);
          default: bus.alu_out = 32'd0;
        endcase
      end
      default: bus.alu_out = {31'b0, flag};
    endcase
  end

  assign bus.overflow = (bus.alu_fun[5:4] == 2'b00) && bus.sign &&
                        (bus.alu_a[31] == b_eff[31]) && (sum[31] != bus.alu_a[31]);

  // Byte offset bits are dropped; anything at or above 4*DEPTH falls outside the RAM
  assign in_range  = (bus.alu_out[31:ADDR_BITS+2] == '0);
  assign idx       = bus.alu_out[ADDR_BITS+1:2];
  assign bus.rdata = (bus.mem_rd && in_range) ? mem[idx] : 32'd0;

`ifdef DMEM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (bus.mem_wr && in_range) begin
      mem[idx] <= bus.wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset && bus.mem_wr && in_range) begin
      mem[idx] <= bus.wdata;
    end
  end
`endif

endmodule

// File: tb/tb_alu_dmem_unit.sv
// Self-checking bench for alu_dmem_unit: arithmetic reference model plus memory array model,
// compared on every falling edge, with hand-computed literal checks for key cases.
module tb_alu_dmem_unit;

  localparam int DEPTH = 256;

  localparam logic [5:0] F_ADD = 6'h00;
  localparam logic [5:0] F_SUB = 6'h01;
  localparam logic [5:0] F_AND = 6'h18;
  localparam logic [5:0] F_OR  = 6'h1E;
  localparam logic [5:0] F_XOR = 6'h16;
  localparam logic [5:0] F_NOR = 6'h11;
  localparam logic [5:0] F_SLL = 6'h20;
  localparam logic [5:0] F_SRL = 6'h21;
  localparam logic [5:0] F_SRA = 6'h23;
  localparam logic [5:0] F_LT  = 6'h35;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  bit   compare_on;

  logic [31:0] mem_model [DEPTH];

  alu_dmem_unit_if bus ();

  alu_dmem_unit #(.DEPTH(DEPTH), .ADDR_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {overflow, result} from plain integer arithmetic
  function automatic logic [32:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [5:0] fun, input logic sg);
    int          ia;
    int          ib;
    longint      wide;
    logic [31:0] res;
    logic        ovf;
    int          sh;
    ia  = int'(a);
    ib  = int'(b);
    sh  = int'(a[4:0]);
    res = 32'd0;
    ovf = 1'b0;
    case (fun[5:4])
      2'b00: begin
        wide = fun[0] ? (longint'(ia) - longint'(ib)) : (longint'(ia) + longint'(ib));
        res  = wide[31:0];
        ovf  = sg && ((wide > 64'sd2147483647) || (wide < -64'sd2147483648));
      end
      2'b01: begin
        case (fun[3:0])
          4'h8:    res = a & b;
          4'hE:    res = a | b;
          4'h6:    res = a ^ b;
          4'h1:    res = ~(a | b);
          4'hA:    res = a;
          default: res = 32'd0;
        endcase
      end
      2'b10: begin
        case (fun[1:0])
          2'b00:   res = b << sh;
          2'b01:   res = b >> sh;
          2'b11:   res = $unsigned(ib >>> sh);
          default: res = 32'd0;
        endcase
      end
      default: begin
        case (fun[3:1])
          3'b001:  res = {31'b0, a == b};
          3'b000:  res = {31'b0, a != b};
          3'b010:  res = {31'b0, sg ? (ia < ib) : (a < b)};
          3'b110:  res = {31'b0, ia <= 0};
          3'b101:  res = {31'b0, ia < 0};
          3'b111:  res = {31'b0, ia > 0};
          default: res = 32'd0;
        endcase
      end
    endcase
    return {ovf, res};
  endfunction

  function automatic logic [31:0] model_rdata(input logic [31:0] addr, input logic rd);
    if (rd && (addr < 32'(4 * DEPTH))) return mem_model[addr / 4];
    return 32'd0;
  endfunction

  // Memory model follows writes that land on rising edges while reset is released
  always @(posedge clk) begin
    logic [32:0] r;
    r = model_alu(bus.alu_a, bus.alu_b, bus.alu_fun, bus.sign);
    if (reset === 1'b1 && bus.mem_wr === 1'b1 && r[31:0] < 32'(4 * DEPTH))
      mem_model[r[31:0] / 4] = bus.wdata;
  end

`ifdef DMEM_RESET_CLEAR_EN
  always @(negedge reset) begin
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'd0;
  end
`endif

  always @(negedge clk) begin
    logic [32:0] r;
    logic [31:0] exp_rd;
    if (compare_on) begin
      r      = model_alu(bus.alu_a, bus.alu_b, bus.alu_fun, bus.sign);
      exp_rd = model_rdata(r[31:0], bus.mem_rd);
      n_checks++;
      if (bus.alu_out !== r[31:0]) begin
        n_fail++;
        $display("[TB] FAIL model_alu_out fun=%h a=%h b=%h: got %h expected %h",
                 bus.alu_fun, bus.alu_a, bus.alu_b, bus.alu_out, r[31:0]);
      end
      n_checks++;
      if (bus.overflow !== r[32]) begin
        n_fail++;
        $display("[TB] FAIL model_overflow fun=%h a=%h b=%h sign=%0b: got %b expected %b",
                 bus.alu_fun, bus.alu_a, bus.alu_b, bus.sign, bus.overflow, r[32]);
      end
      n_checks++;
      if (bus.rdata !== exp_rd) begin
        n_fail++;
        $display("[TB] FAIL model_rdata addr=%h rd=%0b: got %h expected %h",
                 r[31:0], bus.mem_rd, bus.rdata, exp_rd);
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [5:0] fun,
                               input logic sg, input logic rd, input logic wr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.alu_a   = a;
    bus.alu_b   = b;
    bus.alu_fun = fun;
    bus.sign    = sg;
    bus.mem_rd  = rd;
    bus.mem_wr  = wr;
    bus.wdata   = wd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_out, input logic exp_ovf,
                             input bit chk_rd, input logic [31:0] exp_rd);
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.alu_out !== exp_out || bus.overflow !== exp_ovf) begin
      n_fail++;
      $display("[TB] FAIL %s: got out=%h ovf=%b expected out=%h ovf=%b",
               name, bus.alu_out, bus.overflow, exp_out, exp_ovf);
    end
    if (chk_rd) begin
      n_checks++;
      if (bus.rdata !== exp_rd) begin
        n_fail++;
        $display("[TB] FAIL %s_rdata: got %h expected %h", name, bus.rdata, exp_rd);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  fun;
    n_checks    = 0;
    n_fail      = 0;
    compare_on  = 1'b0;
    reset       = 1'b0;
    bus.alu_a   = 32'd0;
    bus.alu_b   = 32'd0;
    bus.alu_fun = F_ADD;
    bus.sign    = 1'b0;
    bus.mem_rd  = 1'b0;
    bus.mem_wr  = 1'b0;
    bus.wdata   = 32'd0;

    checkOutput("reset_state", 32'd0, 1'b0, 1'b1, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Give every word a known value so reads never touch undefined contents
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(32'(4 * i), 32'd0, F_ADD, 1'b0, 1'b0, 1'b1, $urandom);
    applyStimulus(32'd0, 32'd0, F_ADD, 1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    compare_on = 1'b1;

    applyStimulus(32'h7FFFFFFF, 32'd1, F_ADD, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("add_ovf_signed", 32'h80000000, 1'b1, 1'b0, 32'd0);
    applyStimulus(32'h7FFFFFFF, 32'd1, F_ADD, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("add_ovf_unsigned", 32'h80000000, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'd5, 32'd7, F_SUB, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("sub_5_7", 32'hFFFFFFFE, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'hFFFFFFFF, 32'd1, F_LT, 1'b1, 1'b0, 1'b0, 32'd0);
    checkOutput("lt_signed", 32'd1, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'hFFFFFFFF, 32'd1, F_LT, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("lt_unsigned", 32'd0, 1'b0, 1'b0, 32'd0);

    applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, F_AND, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("and", 32'h00F000F0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, F_OR, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("or", 32'hFFF0FFF0, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, F_XOR, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("xor", 32'hFF00FF00, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'hF0F0F0F0, 32'h0FF00FF0, F_NOR, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("nor", 32'h000F000F, 1'b0, 1'b0, 32'd0);

    applyStimulus(32'd4, 32'h80000010, F_SLL, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("sll", 32'h00000100, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'd4, 32'h80000010, F_SRL, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("srl", 32'h08000001, 1'b0, 1'b0, 32'd0);
    applyStimulus(32'd4, 32'h80000010, F_SRA, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("sra", 32'hF8000001, 1'b0, 1'b0, 32'd0);

    applyStimulus(32'h10, 32'd0, F_ADD, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    applyStimulus(32'h10, 32'd0, F_ADD, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("ram_read", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF);
    applyStimulus(32'h10, 32'd0, F_ADD, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("ram_no_rd", 32'h10, 1'b0, 1'b1, 32'd0);
    applyStimulus(32'h400, 32'd0, F_ADD, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D);
    applyStimulus(32'h400, 32'd0, F_ADD, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("ram_oob_read", 32'h400, 1'b0, 1'b1, 32'd0);
    applyStimulus(32'h0, 32'd0, F_ADD, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("ram_word0_kept", 32'h0, 1'b0, 1'b1, 32'h0BADF00D);

    // Same-cycle read and write to one address returns the old contents
    applyStimulus(32'h10, 32'd0, F_ADD, 1'b0, 1'b1, 1'b1, 32'h55AA55AA);
    checkOutput("ram_read_before_write", 32'h10, 1'b0, 1'b1, 32'hDEADBEEF);

    // Reset pulse mid-cycle with a write pending on the edge it spans
    applyStimulus(32'd12, 32'd0, F_ADD, 1'b0, 1'b0, 1'b1, 32'h12345678);
    applyStimulus(32'd12, 32'd0, F_ADD, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_wr = 1'b0;
    #1;
    reset = 1'b1;
    applyStimulus(32'd12, 32'd0, F_ADD, 1'b0, 1'b1, 1'b0, 32'd0);
`ifdef DMEM_RESET_CLEAR_EN
    checkOutput("reset_word3", 32'd12, 1'b0, 1'b1, 32'd0);
`else
    checkOutput("reset_word3", 32'd12, 1'b0, 1'b1, 32'h12345678);
`endif

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(32'($urandom_range(0, 1279)), 32'($urandom_range(0, 3)), F_ADD,
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end else begin
        a   = $urandom;
        b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
        fun = 6'($urandom);
        if ($urandom_range(0, 3) == 0) a = 32'h7FFFFFF0 + 32'($urandom_range(0, 31));
        applyStimulus(a, b, fun, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      end
    end

    @(negedge clk);
    #1;
    compare_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
